// File: rtl/vga_game_pkg.sv
// vga_game_pkg: shared sizes and state encoding for the sprite-layer game logic
package vga_game_pkg;
  localparam int N_ALIENS_DEF = 5;
  localparam int N_MISSLES_DEF = 8;
  localparam int SCORE_W = 16;
  localparam logic [SCORE_W-1:0] POINTS_DEF = 16'd10;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} coll_state_t;
endpackage

// File: rtl/collision_ctrl_if.sv
// collision_ctrl_if: sprite overlap inputs and alive/retire/score outputs of the hit controller
interface collision_ctrl_if #(
  parameter int N_ALIENS = 5,
  parameter int N_MISSLES = 8
);
  logic                 video_on;
  logic                 vblank_start;
  logic                 game_restart;
  logic [N_ALIENS-1:0]  alien_active;
  logic [N_MISSLES-1:0] missle_active;
  logic [N_ALIENS-1:0]  alien_alive;
  logic [N_MISSLES-1:0] missle_kill;
  logic [15:0]          score;
  logic                 all_dead;
  logic                 busy;
  modport master (
    output video_on, vblank_start, game_restart, alien_active, missle_active,
    input  alien_alive, missle_kill, score, all_dead, busy
  );
  modport slave (
    input  video_on, vblank_start, game_restart, alien_active, missle_active,
    output alien_alive, missle_kill, score, all_dead, busy
  );
endinterface

// File: rtl/collision_ctrl_lsb_pick.sv
// lsb_pick: index of the lowest set bit of a vector, plus a found flag
module lsb_pick #(
  parameter int W = 8,
  localparam int IW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = |vec;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/collision_ctrl.sv
// collision_ctrl: captures missile/alien overlaps during video and resolves kills once per frame in vblank
module collision_ctrl
  import vga_game_pkg::*;
#(
  parameter int N_ALIENS = N_ALIENS_DEF,
  parameter int N_MISSLES = N_MISSLES_DEF,
  parameter logic [SCORE_W-1:0] POINTS = POINTS_DEF
) (
  input logic             vga_clk_i,
  input logic             vga_rst_i,
  collision_ctrl_if.slave bus
);
  localparam int MW = N_MISSLES > 1 ? $clog2(N_MISSLES) : 1;
  coll_state_t state, next_state;
  logic [2:0] idx;
  logic [N_ALIENS-1:0][N_MISSLES-1:0] hit;
  logic [N_MISSLES-1:0] used, cand;
  logic found;
  logic [MW-1:0] m;
  logic [19:0] sum;

  function automatic logic [3:0] popcount(input logic [N_MISSLES-1:0] v);
    popcount = '0;
    for (int i = 0; i < N_MISSLES; i++) popcount += 4'(v[i]);
  endfunction

  assign cand = hit[idx] & ~used;

  lsb_pick #(.W(N_MISSLES)) u_pick (.vec(cand), .found(found), .idx(m));

  always_ff @(posedge vga_clk_i)
    state <= (vga_rst_i || bus.game_restart) ? IDLE : next_state;

  always_comb begin
    next_state = state == IDLE ? (bus.vblank_start ? SCAN : IDLE)
               : state == SCAN ? (idx == 3'(N_ALIENS - 1) ? COMMIT : SCAN)
               : IDLE;
    sum = 20'(bus.score) + 20'(popcount(used)) * 20'(POINTS);
  end

  always_ff @(posedge vga_clk_i) begin
    if (vga_rst_i) begin
      bus.alien_alive <= '1;
      bus.missle_kill <= '0;
      bus.score <= '0;
      bus.all_dead <= 1'b0;
      bus.busy <= 1'b0;
      hit <= '0;
      used <= '0;
      idx <= '0;
    end else if (bus.game_restart) begin
      bus.alien_alive <= '1;
      bus.missle_kill <= '0;
      bus.all_dead <= 1'b0;
      bus.busy <= 1'b0;
      hit <= '0;
      used <= '0;
      idx <= '0;
    end else begin
      bus.missle_kill <= '0;
      bus.all_dead <= bus.alien_alive == '0;
      bus.busy <= next_state != IDLE;
      case (state)
        IDLE: begin
          for (int a = 0; a < N_ALIENS; a++)
            if (bus.video_on && bus.alien_active[a] && bus.alien_alive[a])
              hit[a] <= hit[a] | bus.missle_active;
          if (bus.vblank_start) begin
            idx <= '0;
            used <= '0;
          end
        end
        SCAN: begin
          if (found) begin
            bus.alien_alive[idx] <= 1'b0;
            used[m] <= 1'b1;
          end
          idx <= idx + 3'd1;
        end
        default: begin
          bus.missle_kill <= used;
          bus.score <= sum > 20'hFFFF ? 16'hFFFF : sum[15:0];
          hit <= '0;
        end
      endcase
    end
  end
endmodule
